// File: rtl/phase_to_speed.sv
// rtl/phase_to_speed.sv - block-averaged, scaled and saturated phase-to-speed converter
module phase_to_speed #(
    parameter logic [15:0] SCALE = 16'd1024,
    parameter int          SHIFT = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample,
    input  logic [3:0]         meanlen,
    input  logic signed [18:0] phase,
    output logic signed [15:0] speed,
    output logic               ready
);

    localparam logic signed [34:0] ROUND  = 35'sd1 <<< (SHIFT - 1);
    localparam logic signed [34:0] SAT_HI = 35'sd32767;
    localparam logic signed [34:0] SAT_LO = -35'sd32768;

    logic signed [34:0] acc;
    logic        [15:0] cnt;
    logic        [3:0]  len;
    logic signed [18:0] mean;
    logic               mv;

    logic        [3:0]  eff_len;
    logic        [15:0] last_cnt;
    logic               block_end;
    logic signed [34:0] sum;
    logic signed [34:0] product;
    logic signed [34:0] rounded;

    // Block length is taken live from meanlen only at block start, then from the latched copy
    always_comb begin
        eff_len   = (cnt == 16'd0) ? meanlen : len;
        last_cnt  = ~(16'hFFFF << eff_len);
        block_end = sample && (cnt == last_cnt);
        sum       = acc + {{16{phase[18]}}, phase};
        product   = {{16{mean[18]}}, mean} * $signed({19'd0, SCALE});
        rounded   = (product + ROUND) >>> SHIFT;
    end

    // Accumulate accepted samples and produce the floor-rounded block mean
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            cnt  <= '0;
            len  <= '0;
            mean <= '0;
        end else if (sample) begin
            if (cnt == 16'd0) begin
                len <= meanlen;
            end
            if (block_end) begin
                mean <= 19'(sum >>> eff_len);
                acc  <= '0;
                cnt  <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Scale the pending mean one edge later; a fresh block completion re-arms mv on the same edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mv    <= 1'b0;
            speed <= '0;
            ready <= 1'b0;
        end else begin
            ready <= mv;
            mv    <= block_end;
            if (mv) begin
                if (rounded > SAT_HI) begin
                    speed <= 16'sh7FFF;
                end else if (rounded < SAT_LO) begin
                    speed <= 16'sh8000;
                end else begin
                    speed <= rounded[15:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_phase_to_speed.sv
// tb/tb_phase_to_speed.sv - directed self-checking bench for phase_to_speed
module tb_phase_to_speed;

    logic               clock;
    logic               reset;
    logic               sample;
    logic [3:0]         meanlen;
    logic signed [18:0] phase;
    logic signed [15:0] speed_a;
    logic               ready_a;
    logic signed [15:0] speed_s;
    logic               ready_s;

    int checks;
    int errors;

    phase_to_speed u_dut (
        .clock   (clock),
        .reset   (reset),
        .sample  (sample),
        .meanlen (meanlen),
        .phase   (phase),
        .speed   (speed_a),
        .ready   (ready_a)
    );

    phase_to_speed #(.SCALE(16'd65535), .SHIFT(16)) u_sat (
        .clock   (clock),
        .reset   (reset),
        .sample  (sample),
        .meanlen (meanlen),
        .phase   (phase),
        .speed   (speed_s),
        .ready   (ready_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // phase, expected speed at SCALE=1024, expected speed at SCALE=65535
    int tbl_ph [7] = '{65536, -96, -65536, -262144, 262143, 32, -32};
    int tbl_a  [7] = '{1024,  -1,  -1024,  -4096,   4096,   1,  0};
    int tbl_s  [7] = '{32767, -96, -32768, -32768,  32767,  32, -32};

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b0;
        sample  = 1'b0;
        meanlen = 4'd0;
        phase   = '0;
        step();
        step();
        check("reset_speed", int'(speed_a), 0);
        check("reset_ready", int'(ready_a), 0);
        reset = 1'b1;
        step();

        // meanlen=0, constant 1.0 rad
        sample = 1'b1;
        phase  = 19'sd65536;
        step();
        check("ml0_first_edge_ready", int'(ready_a), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ml0_ready", int'(ready_a), 1);
            check("ml0_speed", int'(speed_a), 1024);
        end
        sample = 1'b0;
        step();
        check("ml0_tail_ready", int'(ready_a), 1);
        step();
        check("ml0_idle_ready", int'(ready_a), 0);

        // rounding and saturation, meanlen=0
        for (int i = 0; i < 7; i++) begin
            sample = 1'b1;
            phase  = 19'(tbl_ph[i]);
            step();
            sample = 1'b0;
            step();
            check("tbl_ready", int'(ready_a), 1);
            check("tbl_speed", int'(speed_a), tbl_a[i]);
            check("tbl_sat_speed", int'(speed_s), tbl_s[i]);
        end
        step();

        // meanlen=2, four distinct samples
        meanlen = 4'd2;
        for (int i = 1; i <= 4; i++) begin
            sample = 1'b1;
            phase  = 19'(100 * i);
            step();
            check("ml2_no_ready", int'(ready_a), 0);
        end
        sample = 1'b0;
        step();
        check("ml2_ready", int'(ready_a), 1);
        check("ml2_speed", int'(speed_a), 4);
        step();
        check("ml2_single_pulse", int'(ready_a), 0);
        check("ml2_hold", int'(speed_a), 4);

        // meanlen=1 with gaps in sample
        meanlen = 4'd1;
        sample  = 1'b1;
        phase   = 19'sd1000;
        step();
        sample = 1'b0;
        step();
        check("gap_no_ready_a", int'(ready_a), 0);
        sample = 1'b1;
        phase  = 19'sd3000;
        step();
        check("gap_no_ready_b", int'(ready_a), 0);
        sample = 1'b0;
        step();
        check("gap_ready", int'(ready_a), 1);
        check("gap_speed", int'(speed_a), 31);
        step();

        // meanlen change mid-block affects only the next block
        sample = 1'b1;
        phase  = 19'sd640;
        step();
        meanlen = 4'd3;
        phase   = 19'sd1280;
        step();
        check("len_latched_no_ready", int'(ready_a), 0);
        phase = 19'sd6400;
        step();
        check("len_latched_ready", int'(ready_a), 1);
        check("len_latched_speed", int'(speed_a), 15);
        for (int i = 0; i < 7; i++) begin
            step();
            check("ml3_no_ready", int'(ready_a), 0);
        end
        sample = 1'b0;
        step();
        check("ml3_ready", int'(ready_a), 1);
        check("ml3_speed", int'(speed_a), 100);

        // asynchronous reset mid-block discards the partial block
        step();
        meanlen = 4'd2;
        sample  = 1'b1;
        phase   = 19'sd65536;
        step();
        step();
        sample = 1'b0;
        check("pre_reset_speed", int'(speed_a), 100);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_speed", int'(speed_a), 0);
        check("async_reset_ready", int'(ready_a), 0);
        step();
        reset = 1'b1;
        sample = 1'b1;
        phase  = 19'sd6400;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_reset_no_ready", int'(ready_a), 0);
        end
        sample = 1'b0;
        step();
        check("post_reset_ready", int'(ready_a), 1);
        check("post_reset_speed", int'(speed_a), 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
